// File: rtl/mem_access_controller.sv
// Bridges the control unit's memory handshake to a 32-bit word bus: RV64 byte..double
// loads/stores with lane steering, load extension, alignment checking and a bus watchdog.
module mem_access_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_start,
  input  logic        sel_mem_operation,
  input  logic [1:0]  sel_mem_size,
  input  logic [2:0]  sel_mem_extension,
  input  logic [63:0] addr,
  input  logic [63:0] write_data,
  output logic [63:0] read_data,
  output logic        memory_done,
  output logic        mem_error,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);
  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;

  localparam logic [1:0]  SIZE_BYTE   = 2'b00;
  localparam logic [1:0]  SIZE_HALF   = 2'b01;
  localparam logic [1:0]  SIZE_WORD   = 2'b10;
  localparam logic [1:0]  SIZE_DOUBLE = 2'b11;
  localparam bit          TMO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT_CYCLES) - 32'd1;

  state_t      state;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        op_q;
  logic        zext_q;
  logic [31:0] wdata_hi_q;
  logic [31:0] low_word_q;
  logic [31:0] tmo_cnt;

  logic        aligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [63:0] load_result;
  logic        timeout_hit;

  // Only funct3 bit 2 (unsigned load) affects this block.
  logic unused_ext;
  assign unused_ext = ^sel_mem_extension[1:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    aligned    = 1'b1;
    lane_wdata = write_data[31:0];
    lane_wstrb = 4'b1111;
    unique case (sel_mem_size)
      SIZE_BYTE: begin
        lane_wdata = {4{write_data[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      SIZE_HALF: begin
        aligned    = ~addr[0];
        lane_wdata = {2{write_data[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      SIZE_WORD:   aligned = (addr[1:0] == 2'b00);
      SIZE_DOUBLE: aligned = (addr[2:0] == 3'b000);
    endcase
  end

  always_comb begin
    load_result = '0;
    rd_byte     = mem_rdata[{lane_q, 3'b000} +: 8];
    rd_half     = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    unique case (size_q)
      SIZE_BYTE:   load_result = zext_q ? {56'd0, rd_byte} : {{56{rd_byte[7]}}, rd_byte};
      SIZE_HALF:   load_result = zext_q ? {48'd0, rd_half} : {{48{rd_half[15]}}, rd_half};
      SIZE_WORD:   load_result = zext_q ? {32'd0, mem_rdata} : {{32{mem_rdata[31]}}, mem_rdata};
      SIZE_DOUBLE: load_result = {mem_rdata, low_word_q};
    endcase
  end

  // An ack arriving on the last allowed cycle wins over the watchdog.
  assign timeout_hit = TMO_EN && !mem_ack && (tmo_cnt == TMO_LAST);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // right-hand side sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      memory_done <= 1'b0;
      mem_error   <= 1'b0;
      read_data   <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      tmo_cnt     <= '0;
      lane_q      <= '0;
      size_q      <= '0;
      op_q        <= 1'b0;
      zext_q      <= 1'b0;
      wdata_hi_q  <= '0;
      low_word_q  <= '0;
    end else begin
      memory_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (memory_start) begin
            lane_q     <= addr[1:0];
            size_q     <= sel_mem_size;
            op_q       <= sel_mem_operation;
            zext_q     <= sel_mem_extension[2];
            wdata_hi_q <= write_data[63:32];
            if (!aligned) begin
              state       <= DONE;
              memory_done <= 1'b1;
              mem_error   <= 1'b1;
              read_data   <= '0;
            end else begin
              state     <= BEAT0;
              mem_req   <= 1'b1;
              mem_we    <= sel_mem_operation;
              mem_addr  <= {addr[63:2], 2'b00};
              mem_wdata <= lane_wdata;
              mem_wstrb <= sel_mem_operation ? lane_wstrb : 4'b0000;
              mem_error <= 1'b0;
              tmo_cnt   <= '0;
            end
          end
        end
        BEAT0, BEAT1: begin
          if (mem_ack) begin
            if (state == BEAT0 && size_q == SIZE_DOUBLE) begin
              state      <= BEAT1;
              low_word_q <= mem_rdata;
              mem_addr   <= mem_addr + 64'd4;
              mem_wdata  <= wdata_hi_q;
              tmo_cnt    <= '0;
            end else begin
              state       <= DONE;
              memory_done <= 1'b1;
              mem_req     <= 1'b0;
              mem_we      <= 1'b0;
              if (!op_q) read_data <= load_result;
            end
          end else if (timeout_hit) begin
            state       <= DONE;
            memory_done <= 1'b1;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_error   <= 1'b1;
            read_data   <= '0;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        DONE: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_controller.sv
// Randomized scoreboard bench for mem_access_controller: a bus responder checks each beat,
// a monitor checks every completion against a reference model of the access rules.
module tb_mem_access_controller;
  localparam int TMO    = 4;
  localparam int NO_ACK = -1;

  typedef struct {
    logic [63:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    int          waits;
  } beat_t;

  typedef struct {
    logic [63:0] rd;
    logic        err;
    int          cyc;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        memory_start;
  logic        sel_mem_operation;
  logic [1:0]  sel_mem_size;
  logic [2:0]  sel_mem_extension;
  logic [63:0] addr;
  logic [63:0] write_data;
  logic [63:0] read_data;
  logic        memory_done;
  logic        mem_error;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  beat_t       beat_q[$];
  resp_t       exp_q[$];
  logic [63:0] last_rd;

  mem_access_controller #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .memory_start(memory_start),
    .sel_mem_operation(sel_mem_operation), .sel_mem_size(sel_mem_size),
    .sel_mem_extension(sel_mem_extension), .addr(addr), .write_data(write_data),
    .read_data(read_data), .memory_done(memory_done), .mem_error(mem_error),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%h want 0x%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bus responder: checks each requested beat against the queued expectation and acks it.
  initial begin : responder
    beat_t cur;
    bit    in_beat;
    int    held;
    int    waited;
    in_beat   = 1'b0;
    held      = 0;
    waited    = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset) begin
        in_beat = 1'b0;
        continue;
      end
      if (in_beat && !mem_req) begin
        if (cur.waits == NO_ACK) check("tmo_req_cycles", 64'(held), 64'(TMO));
        else check("req_dropped_early", 64'(mem_req), 64'd1);
        in_beat = 1'b0;
      end
      if (mem_req && !in_beat) begin
        if (beat_q.size() == 0) check("unexpected_req", 64'(mem_req), 64'd0);
        else begin
          cur     = beat_q.pop_front();
          in_beat = 1'b1;
          held    = 0;
          waited  = 0;
        end
      end
      if (in_beat) begin
        check("beat_addr", mem_addr, cur.addr);
        check("beat_we", 64'(mem_we), 64'(cur.we));
        check("beat_wstrb", 64'(mem_wstrb), 64'(cur.wstrb));
        if (cur.we) check("beat_wdata", 64'(mem_wdata), 64'(cur.wdata));
        held++;
        if (cur.waits != NO_ACK && waited == cur.waits) begin
          mem_ack   = 1'b1;
          mem_rdata = cur.rdata;
          in_beat   = 1'b0;
        end else begin
          waited++;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Completion monitor: every memory_done pops one expected response.
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (!reset && memory_done) begin
        if (exp_q.size() == 0) check("spurious_done", 64'(memory_done), 64'd0);
        else begin
          r = exp_q.pop_front();
          check("read_data", read_data, r.rd);
          check("mem_error", 64'(mem_error), 64'(r.err));
          check("done_cycle", 64'(cyc), 64'(r.cyc));
        end
      end
    end
  end

  // Reference model: derives bus beats, result and completion cycle from the access rules.
  task automatic access(input logic [63:0] a, input logic [1:0] sz, input logic op,
                        input logic [2:0] ext, input logic [63:0] wd,
                        input logic [31:0] r0, input logic [31:0] r1,
                        input int w0, input int w1);
    beat_t       b;
    resp_t       r;
    int          off;
    int          nbeats;
    int          lat;
    int          bits;
    int          n;
    bit          mis;
    bit          tmo;
    logic [63:0] v;
    logic [31:0] rdw[2];
    int          wt[2];
    @(negedge clk);
    rdw[0] = r0; rdw[1] = r1; wt[0] = w0; wt[1] = w1;
    off    = int'(a % 64'd4);
    mis    = (a % (64'd1 << sz)) != 64'd0;
    nbeats = (sz == 2'd3) ? 2 : 1;
    tmo    = 1'b0;
    lat    = 1;
    if (!mis) begin
      for (int k = 0; k < nbeats; k++) begin
        b.addr  = (a & ~64'h3) + 64'(4 * k);
        b.we    = op;
        b.wstrb = !op ? 4'h0 : (sz == 2'd0) ? 4'(1 << off) : (sz == 2'd1) ? 4'(3 << off) : 4'hF;
        b.wdata = (sz == 2'd0) ? 32'(wd[7:0]) * 32'h0101_0101 :
                  (sz == 2'd1) ? 32'(wd[15:0]) * 32'h0001_0001 :
                  (k == 0) ? wd[31:0] : wd[63:32];
        b.rdata = rdw[k];
        b.waits = wt[k];
        beat_q.push_back(b);
        if (wt[k] == NO_ACK) begin
          tmo = 1'b1;
          lat += TMO;
          break;
        end
        lat += wt[k] + 1;
      end
    end
    if (mis || tmo) begin
      v = '0;
    end else if (op) begin
      v = last_rd;
    end else begin
      case (sz)
        2'd0:    begin v = (64'(r0) >> (off * 8)) & 64'hFF;   bits = 8;  end
        2'd1:    begin v = (64'(r0) >> (off * 8)) & 64'hFFFF; bits = 16; end
        2'd2:    begin v = 64'(r0);                           bits = 32; end
        default: begin v = {r1, r0};                          bits = 64; end
      endcase
      if (bits < 64 && !ext[2] && v[bits-1]) v = v | ~((64'd1 << bits) - 64'd1);
    end
    last_rd = v;
    r.rd  = v;
    r.err = mis || tmo;
    r.cyc = cyc + lat;
    exp_q.push_back(r);
    addr = a; sel_mem_size = sz; sel_mem_operation = op;
    sel_mem_extension = ext; write_data = wd; memory_start = 1'b1;
    @(negedge clk);
    memory_start = 1'b0;
    n = 0;
    while ((exp_q.size() != 0 || beat_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n == 200) begin
      check("drain_timeout", 64'(exp_q.size() + beat_q.size()), 64'd0);
      exp_q.delete();
      beat_q.delete();
    end
  endtask

  initial begin : stim
    beat_t       b;
    int          n;
    logic [1:0]  sz;
    logic [63:0] a;
    int          w0;
    int          w1;
    reset = 1'b1; memory_start = 1'b0; sel_mem_operation = 1'b0; sel_mem_size = '0;
    sel_mem_extension = '0; addr = '0; write_data = '0; last_rd = '0;
    repeat (2) @(negedge clk);
    check("rst_mem_req", 64'(mem_req), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_done", 64'(memory_done), 64'd0);
    check("rst_error", 64'(mem_error), 64'd0);
    check("rst_read_data", read_data, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    reset = 1'b0;

    access(64'h1000, 2'd2, 1'b0, 3'b010, 64'h0, 32'h8000_0001, 32'h0, 2, 0);
    access(64'h1003, 2'd0, 1'b0, 3'b000, 64'h0, 32'h9A00_0000, 32'h0, 0, 0);
    access(64'h1003, 2'd0, 1'b0, 3'b100, 64'h0, 32'h9A00_0000, 32'h0, 1, 0);
    access(64'h2002, 2'd1, 1'b1, 3'b001, 64'h1234_ABCD, 32'h0, 32'h0, 0, 0);
    access(64'h3008, 2'd3, 1'b0, 3'b011, 64'h0, 32'h1111_2222, 32'h3333_4444, 0, 1);
    access(64'h3010, 2'd3, 1'b1, 3'b011, 64'hDEAD_BEEF_0BAD_F00D, 32'h0, 32'h0, 1, 0);
    access(64'h4002, 2'd2, 1'b0, 3'b010, 64'h0, 32'h0, 32'h0, 0, 0);
    access(64'h4000, 2'd2, 1'b0, 3'b010, 64'h0, 32'h0, 32'h0, NO_ACK, 0);
    access(64'h4000, 2'd2, 1'b0, 3'b010, 64'h0, 32'h7FFF_FFFF, 32'h0, TMO - 1, 0);
    access(64'h4006, 2'd1, 1'b0, 3'b001, 64'h0, 32'h8001_1234, 32'h0, 0, 0);

    // Reset while the second beat of a double load is outstanding.
    @(negedge clk);
    b = '{addr: 64'h5000, we: 1'b0, wdata: 32'h0, wstrb: 4'h0, rdata: 32'hAAAA_5555, waits: 0};
    beat_q.push_back(b);
    b = '{addr: 64'h5004, we: 1'b0, wdata: 32'h0, wstrb: 4'h0, rdata: 32'h0, waits: NO_ACK};
    beat_q.push_back(b);
    addr = 64'h5000; sel_mem_size = 2'd3; sel_mem_operation = 1'b0;
    sel_mem_extension = 3'b011; memory_start = 1'b1;
    @(negedge clk);
    memory_start = 1'b0;
    n = 0;
    while (!(mem_req && mem_addr == 64'h5004) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_beat1", mem_addr, 64'h5004);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_req", 64'(mem_req), 64'd0);
    check("rst_mid_done", 64'(memory_done), 64'd0);
    @(negedge clk);
    beat_q.delete();
    exp_q.delete();
    reset   = 1'b0;
    last_rd = '0;
    access(64'h5000, 2'd2, 1'b0, 3'b110, 64'h0, 32'hCAFE_0001, 32'h0, 1, 0);

    for (int i = 0; i < 80; i++) begin
      sz = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
      w0 = $urandom_range(0, TMO - 1);
      w1 = $urandom_range(0, TMO - 1);
      if ($urandom_range(0, 9) == 0) w0 = NO_ACK;
      else if ($urandom_range(0, 9) == 0) w1 = NO_ACK;
      access(a, sz, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             {$urandom, $urandom}, $urandom, $urandom, w0, w1);
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Sits between the control unit's memory handshake (memory_start / memory_done / sel_mem_size / sel_mem_operation / sel_mem_extension) and a 32-bit word-addressed memory bus.
- Serves instruction fetches and all RV64 load/store sizes: byte, half, word and double. A double access is split into two 32-bit beats.
- Performs byte-lane steering, write strobes, and sign/zero extension of loads.
- Flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, default 0: maximum cycles mem_req may wait for mem_ack on one beat. 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- memory_start  in  1  access request from the control unit; sampled only in IDLE
- sel_mem_operation  in  1  0 = read, 1 = write
- sel_mem_size  in  2  00 = byte, 01 = half, 10 = word, 11 = double
- sel_mem_extension  in  3  funct3 of the access; bit 2 = 1 selects zero-extend on reads
- addr  in  64  byte address of the access
- write_data  in  64  store data; the low bytes are used per size
- read_data  out  64  extended load result; holds until the next access is accepted
- memory_done  out  1  one-cycle completion pulse
- mem_error  out  1  set at done for a misaligned or timed-out access; holds like read_data
- mem_req  out  1  bus request; held until mem_ack
- mem_we  out  1  bus write enable
- mem_addr  out  64  word-aligned bus address (low 2 bits = 0)
- mem_wdata  out  32  bus write data
- mem_wstrb  out  4  byte-lane write strobes
- mem_rdata  in  32  bus read data; valid when mem_ack = 1
- mem_ack  in  1  bus completion for the current beat

Behaviour:
- Reset values: state IDLE; mem_req, mem_we, memory_done, mem_error = 0; read_data, mem_addr, mem_wdata, mem_wstrb = 0; timeout counter = 0.
- Reset mid-access: mem_req drops at the next edge, no memory_done is issued, and the partial double beat is discarded.
- States: IDLE, BEAT0, BEAT1, DONE.
- IDLE + memory_start:
  - Latch addr, write_data, size, op and extension.
  - Check alignment: half needs addr[0] = 0; word needs addr[1:0] = 0; double needs addr[2:0] = 0; byte is always aligned.
  - Misaligned: go to DONE with mem_error = 1 and read_data = 0; no bus cycle is issued.
  - Aligned: go to BEAT0.
- BEAT0:
  - mem_req = 1, mem_addr = {addr[63:2], 2'b00}.
  - mem_addr, mem_we, mem_wdata and mem_wstrb stay stable while mem_req = 1.
  - On mem_ack: a double goes to BEAT1 and stores mem_rdata as the low word; any other size goes to DONE.
- BEAT1: mem_req = 1, mem_addr = BEAT0 address + 4. On mem_ack, go to DONE.
- DONE: memory_done = 1 for exactly one cycle, then IDLE. memory_start is ignored in DONE. The requester deasserts start the cycle after done.
- Minimum latency (start seen at cycle 0, ack in the same cycle as req):
  - memory_done at cycle 2 for single-beat accesses.
  - memory_done at cycle 3 for double.
  - Misaligned accesses: memory_done at cycle 1.
- Write lane steering:
  - byte: mem_wdata = {4{wd[7:0]}}, mem_wstrb = 0001 << addr[1:0].
  - half: mem_wdata = {2{wd[15:0]}}, mem_wstrb = 0011 << addr[1:0].
  - word: mem_wdata = wd[31:0], mem_wstrb = 1111.
  - double: beat 0 sends wd[31:0], beat 1 sends wd[63:32], both with mem_wstrb = 1111.
  - Reads drive mem_wstrb = 0000.
- Read extraction: select the byte or half at addr[1:0] from mem_rdata.
  - Sign-extend to 64 bits unless sel_mem_extension[2] = 1, in which case zero-extend.
  - Word is extended the same way.
  - Double result = {beat1 rdata, beat0 rdata}.
  - read_data is registered on entry to DONE.
- Writes leave read_data unchanged.
- mem_error clears on the next accepted access.
- Timeout (TIMEOUT_CYCLES = N > 0):
  - The counter starts at 0 on entry to each beat and increments each cycle mem_req = 1 without mem_ack.
  - When it reaches N, drop mem_req, go to DONE with mem_error = 1 and read_data = 0.
  - A mem_ack in the same cycle as the counter reaching N wins: normal completion.

Test Plan:
- Word read: addr = 0x1000, ack after 2 wait cycles, mem_rdata = 0x8000_0001, ext = 010 -> read_data = 0xFFFF_FFFF_8000_0001; memory_done pulses once, 1 cycle long.
- LB vs LBU: addr = 0x1003, mem_rdata = 0x9A00_0000 -> ext 000 gives 0xFFFF_FFFF_FFFF_FF9A; ext 100 gives 0x0000_0000_0000_009A.
- SH: addr = 0x2002, write_data = 0x1234_ABCD -> mem_addr = 0x2000, mem_wdata = 0xABCD_ABCD, mem_wstrb = 1100, mem_we = 1.
- LD: addr = 0x3008, beat 0 rdata = 0x1111_2222, beat 1 rdata = 0x3333_4444 with 1 wait -> mem_addr 0x3008 then 0x300C; read_data = 0x3333_4444_1111_2222; no mem_req gap issues.
- Misaligned LW at 0x4002 -> mem_req never asserts; memory_done at cycle 1; mem_error = 1; read_data = 0.
- TIMEOUT_CYCLES = 4, no ack -> mem_req drops after 4 cycles; done with mem_error = 1.
- Reset asserted during BEAT1 -> mem_req = 0 next cycle, no done pulse, and the next access completes normally.
